// File: rtl/mac_job_sequencer_pkg.sv
// Shared types and constants for the mac_cluster job sequencer.
// Mode encodings match the cluster's cfg[1:0] field.
package mac_job_sequencer_pkg;

  localparam int MAC_MIN_W    = 8;
  localparam int MAC_ACC_W    = 32;
  localparam int MAC_CONF_W   = 3;
  localparam int MAC_LEN_W    = 16;
  localparam int MAC_PIPE_LAT = 2;

  localparam logic [1:0] MAC_SINGLE  = 2'b00;
  localparam logic [1:0] MAC_DUAL    = 2'b01;
  localparam logic [1:0] MAC_QUAD    = 2'b10;
  localparam logic [1:0] MAC_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_LOAD  = 3'd1,
    SEQ_RUN   = 3'd2,
    SEQ_DRAIN = 3'd3,
    SEQ_RESP  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/mac_job_sequencer_if.sv
// Job, operand, response and cluster-side signals of the sequencer.
// master = fabric/cluster side, slave = sequencer side.
interface mac_job_sequencer_if
  import mac_job_sequencer_pkg::*;
#(
  parameter int MIN_W  = MAC_MIN_W,
  parameter int ACC_W  = MAC_ACC_W,
  parameter int CONF_W = MAC_CONF_W,
  parameter int LEN_W  = MAC_LEN_W
);

  logic                      job_valid;
  logic                      job_ready;
  logic [1:0]                job_mode;
  logic                      job_acc;
  logic [LEN_W-1:0]          job_len;
  logic [4*ACC_W-1:0]        job_init;

  logic                      op_valid;
  logic                      op_ready;
  logic [4*MIN_W-1:0]        op_a;
  logic [4*MIN_W-1:0]        op_b;

  logic                      mac_rst;
  logic                      mac_en;
  logic [4*ACC_W+CONF_W-1:0] mac_cfg;
  logic [4*MIN_W-1:0]        mac_a;
  logic [4*MIN_W-1:0]        mac_b;
  logic [4*ACC_W-1:0]        mac_out;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [4*ACC_W-1:0]        rsp_data;
  logic                      rsp_err;
  logic                      busy;

  modport master (
    output job_valid, job_mode, job_acc,
    output job_len, job_init,
    output op_valid, op_a, op_b,
    output rsp_ready, mac_out,
    input  job_ready, op_ready,
    input  mac_rst, mac_en, mac_cfg,
    input  mac_a, mac_b,
    input  rsp_valid, rsp_data, rsp_err,
    input  busy
  );

  modport slave (
    input  job_valid, job_mode, job_acc,
    input  job_len, job_init,
    input  op_valid, op_a, op_b,
    input  rsp_ready, mac_out,
    output job_ready, op_ready,
    output mac_rst, mac_en, mac_cfg,
    output mac_a, mac_b,
    output rsp_valid, rsp_data, rsp_err,
    output busy
  );

endinterface

// File: rtl/mac_job_sequencer.sv
// Job-level controller: loads a mac_cluster, streams operand beats,
// drains the pipeline and returns the accumulator lanes.
module mac_job_sequencer
  import mac_job_sequencer_pkg::*;
#(
  parameter int MIN_W   = MAC_MIN_W,
  parameter int ACC_W   = MAC_ACC_W,
  parameter int CONF_W  = MAC_CONF_W,
  parameter int LEN_W   = MAC_LEN_W,
  parameter int MAC_LAT = MAC_PIPE_LAT
) (
  input  logic                clk,
  input  logic                rst_n,
  mac_job_sequencer_if.slave  bus
);

  localparam int DAT_W = 4 * ACC_W;
  localparam int CFG_W = DAT_W + CONF_W;
  localparam int OP_W  = 4 * MIN_W;
  localparam int DR_W  = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [DR_W-1:0] DR_LAST = DR_W'(MAC_LAT - 1);

  seq_state_e        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DR_W-1:0]   drn_q, drn_d;
  logic [CFG_W-1:0]  cfg_q, cfg_d;
  logic [DAT_W-1:0]  rsp_q, rsp_d;
  logic              err_q, err_d;

  logic              job_rdy;
  logic              op_rdy;
  logic              en;
  logic              cfg_live;
  logic [OP_W-1:0]   a;
  logic [OP_W-1:0]   b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEQ_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      drn_q   <= '0;
      cfg_q   <= '0;
      rsp_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      drn_q   <= drn_d;
      cfg_q   <= cfg_d;
      rsp_q   <= rsp_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    cfg_d   = cfg_q;
    rsp_d   = rsp_q;
    err_d   = err_q;
    job_rdy = 1'b0;
    op_rdy  = 1'b0;
    en      = 1'b0;
    a       = '0;
    b       = '0;
    unique case (state_q)
      SEQ_IDLE: begin
        job_rdy = 1'b1;
        if (bus.job_valid) begin
          // Empty and illegal jobs answer directly, never touching the cluster.
          priority case (1'b1)
            (bus.job_len == '0): begin
              rsp_d   = bus.job_init;
              err_d   = 1'b0;
              state_d = SEQ_RESP;
            end
            (bus.job_mode == MAC_ILLEGAL): begin
              rsp_d   = '0;
              err_d   = 1'b1;
              state_d = SEQ_RESP;
            end
            default: begin
              cfg_d   = {bus.job_init, bus.job_acc,
                         bus.job_mode};
              len_d   = bus.job_len;
              cnt_d   = '0;
              state_d = SEQ_LOAD;
            end
          endcase
        end
      end
      SEQ_LOAD: state_d = SEQ_RUN;
      SEQ_RUN: begin
        op_rdy = 1'b1;
        en     = bus.op_valid;
        if (bus.op_valid) begin
          a     = bus.op_a;
          b     = bus.op_b;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == len_q - 1'b1) begin
            drn_d   = '0;
            state_d = SEQ_DRAIN;
          end
        end
      end
      SEQ_DRAIN: begin
        en = 1'b1;
        // Sample before the last edge so zero operands never land.
        if (drn_q == DR_LAST) begin
          rsp_d   = bus.mac_out;
          err_d   = 1'b0;
          state_d = SEQ_RESP;
        end else begin
          drn_d = drn_q + 1'b1;
        end
      end
      SEQ_RESP: begin
        if (bus.rsp_ready) state_d = SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  assign cfg_live = (state_q == SEQ_LOAD) ||
                    (state_q == SEQ_RUN) ||
                    (state_q == SEQ_DRAIN);

  assign bus.job_ready = job_rdy;
  assign bus.op_ready  = op_rdy;
  assign bus.mac_en    = en;
  assign bus.mac_a     = a;
  assign bus.mac_b     = b;
  assign bus.mac_cfg   = cfg_live ? cfg_q : '0;
  assign bus.mac_rst   = ~rst_n | (state_q == SEQ_LOAD);
  assign bus.rsp_valid = (state_q == SEQ_RESP);
  assign bus.rsp_data  = rsp_q;
  assign bus.rsp_err   = err_q;
  assign bus.busy      = (state_q != SEQ_IDLE);

endmodule

// File: tb/tb_mac_job_sequencer.sv
// Directed bench for mac_job_sequencer with a behavioural mac_cluster
// and a response scoreboard.
module tb_mac_job_sequencer;
  import mac_job_sequencer_pkg::*;

  typedef struct {
    logic [127:0] data;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   hs_cyc = 0;
  int   en_cnt = 0;
  int   ordy_cnt = 0;
  int   hs_cnt = 0;
  exp_t sb[$];
  logic [31:0] ba[4];
  logic [31:0] bb[4];
  logic [127:0] cl_acc;
  logic [127:0] cl_p;

  always #5 clk = ~clk;

  mac_job_sequencer_if bus ();

  mac_job_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [127:0] prod(
    input logic [31:0] a, input logic [31:0] b,
    input logic [1:0] m);
    logic [127:0] r;
    logic [31:0]  x, y;
    logic [63:0]  u, v;
    r = '0;
    case (m)
      MAC_SINGLE:
        for (int i = 0; i < 4; i++) begin
          x = {24'b0, a[8*i+:8]};
          y = {24'b0, b[8*i+:8]};
          r[32*i+:32] = x * y;
        end
      MAC_DUAL:
        for (int i = 0; i < 2; i++) begin
          u = {48'b0, a[16*i+:16]};
          v = {48'b0, b[16*i+:16]};
          r[64*i+:64] = u * v;
        end
      default: begin
        u = {32'b0, a};
        v = {32'b0, b};
        r[63:0] = u * v;
      end
    endcase
    return r;
  endfunction

  function automatic logic [127:0] add(
    input logic [127:0] x, input logic [127:0] y,
    input logic [1:0] m);
    logic [127:0] r;
    case (m)
      MAC_SINGLE:
        for (int i = 0; i < 4; i++)
          r[32*i+:32] = x[32*i+:32] + y[32*i+:32];
      MAC_DUAL:
        for (int i = 0; i < 2; i++)
          r[64*i+:64] = x[64*i+:64] + y[64*i+:64];
      default: r = x + y;
    endcase
    return r;
  endfunction

  // Cluster: product stage then accumulate stage, frozen when disabled.
  always @(posedge clk) begin
    if (bus.mac_rst) begin
      cl_p   <= '0;
      cl_acc <= bus.mac_cfg[130:3];
    end else if (bus.mac_en) begin
      cl_p   <= prod(bus.mac_a, bus.mac_b, bus.mac_cfg[1:0]);
      cl_acc <= bus.mac_cfg[2] ?
                add(cl_acc, cl_p, bus.mac_cfg[1:0]) : cl_p;
    end
  end
  assign bus.mac_out = cl_acc;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mac_en) en_cnt <= en_cnt + 1;
    if (bus.op_ready) ordy_cnt <= ordy_cnt + 1;
    if (bus.op_valid && bus.op_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_job(input logic [1:0] m, input logic ac,
                          input logic [15:0] len,
                          input logic [127:0] init);
    int n;
    n = 0;
    bus.job_mode  = m;
    bus.job_acc   = ac;
    bus.job_len   = len;
    bus.job_init  = init;
    bus.job_valid = 1'b1;
    while (!bus.job_ready && n < 20) begin
      tick();
      n++;
    end
    chk("job_wait", 256'(bus.job_ready), 256'(1));
    hs_cyc = cyc;
    tick();
    bus.job_valid = 1'b0;
  endtask

  task automatic feed(input int n, input bit bubble);
    int k, idx;
    logic v, rdy;
    k = 0;
    idx = 0;
    while (idx < n && k < 200) begin
      v = bubble ? (k % 2 == 1) : 1'b1;
      bus.op_valid = v;
      bus.op_a = v ? ba[idx] : '0;
      bus.op_b = v ? bb[idx] : '0;
      rdy = bus.op_ready;
      tick();
      k++;
      if (v && rdy) idx++;
    end
    bus.op_valid = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    chk("feed_beats", 256'(idx), 256'(n));
  endtask

  task automatic get_rsp(input string tag, input int lat,
                         input int hold);
    int n;
    exp_t e;
    n = 0;
    while (!bus.rsp_valid && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_rsp_wait"}, 256'(bus.rsp_valid), 256'(1));
    if (!bus.rsp_valid) return;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 256'(0), 256'(1));
      return;
    end
    e = sb.pop_front();
    if (lat >= 0)
      chk({tag, "_lat"}, 256'(cyc - hs_cyc), 256'(lat));
    chk({tag, "_data"}, 256'(bus.rsp_data), 256'(e.data));
    chk({tag, "_err"}, 256'(bus.rsp_err), 256'(e.err));
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold"},
          {bus.rsp_data, bus.rsp_err, bus.rsp_valid,
           bus.job_ready, bus.busy},
          {e.data, e.err, 1'b1, 1'b0, 1'b1});
      tick();
    end
    bus.rsp_ready = 1'b1;
    chk({tag, "_jrdy_hs"}, 256'(bus.job_ready), 256'(0));
    tick();
    bus.rsp_ready = 1'b0;
    chk({tag, "_idle"}, 256'({bus.busy, bus.job_ready}),
        256'(2'b01));
  endtask

  task automatic set_beats(input logic [31:0] a0,
                           input logic [31:0] b0,
                           input logic [31:0] a1,
                           input logic [31:0] b1);
    ba[0] = a0; bb[0] = b0;
    ba[1] = a1; bb[1] = b1;
    ba[2] = a1; bb[2] = b1;
    ba[3] = a1; bb[3] = b1;
  endtask

  task automatic test_basic(input string tag, input bit bubble,
                            input int lat);
    int h0;
    set_beats(32'h02020202, 32'h03030303,
              32'h02020202, 32'h03030303);
    sb.push_back('{{4{32'd18}}, 1'b0});
    send_job(MAC_SINGLE, 1'b1, 16'd3, '0);
    h0 = hs_cnt;
    feed(3, bubble);
    get_rsp(tag, lat, 0);
    chk({tag, "_ophs"}, 256'(hs_cnt - h0), 256'(3));
  endtask

  initial begin
    int e0, o0;
    bus.job_valid = 1'b0;
    bus.job_mode  = '0;
    bus.job_acc   = 1'b0;
    bus.job_len   = '0;
    bus.job_init  = '0;
    bus.op_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.rsp_ready = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_ctl",
        256'({bus.rsp_valid, bus.rsp_err, bus.op_ready,
              bus.mac_en, bus.busy, bus.mac_rst}),
        256'(6'b000001));
    chk("rst_data", 256'(bus.rsp_data), 256'(0));
    chk("rst_cfg", 256'(bus.mac_cfg), 256'(0));
    chk("rst_ab", 256'({bus.mac_a, bus.mac_b}), 256'(0));
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    test_basic("t1", 1'b0, 7);
    test_basic("t2", 1'b1, 9);

    set_beats(32'h04040404, 32'h04040404,
              32'h05050505, 32'h07070707);
    sb.push_back('{{4{32'd35}}, 1'b0});
    send_job(MAC_SINGLE, 1'b0, 16'd2, {4{32'd100}});
    feed(2, 1'b0);
    get_rsp("t3mul", 6, 0);

    set_beats(32'h02031234, 32'h04050101,
              32'h0, 32'h0);
    sb.push_back('{128'h00000000_0008160F_00000000_00124634,
                   1'b0});
    send_job(MAC_DUAL, 1'b1, 16'd1, '0);
    feed(1, 1'b0);
    get_rsp("t3dual", 5, 0);

    e0 = en_cnt;
    o0 = ordy_cnt;
    sb.push_back('{{32'd4, 32'd3, 32'd2, 32'd1}, 1'b0});
    send_job(MAC_SINGLE, 1'b1, 16'd0,
             {32'd4, 32'd3, 32'd2, 32'd1});
    get_rsp("t4", 1, 0);
    chk("t4_no_en", 256'(en_cnt - e0), 256'(0));
    chk("t4_no_ordy", 256'(ordy_cnt - o0), 256'(0));

    e0 = en_cnt;
    sb.push_back('{128'h0, 1'b1});
    send_job(MAC_ILLEGAL, 1'b1, 16'd5, {4{32'hDEADBEEF}});
    get_rsp("t5", 1, 5);
    chk("t5_no_en", 256'(en_cnt - e0), 256'(0));

    set_beats(32'h02020202, 32'h03030303,
              32'h02020202, 32'h03030303);
    send_job(MAC_SINGLE, 1'b1, 16'd3, {4{32'd9}});
    feed(1, 1'b0);
    chk("t6_run", 256'({bus.busy, bus.op_ready}), 256'(2'b11));
    bus.op_valid = 1'b1;
    bus.op_a = ba[1];
    bus.op_b = bb[1];
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ctl",
        256'({bus.rsp_valid, bus.rsp_err, bus.op_ready,
              bus.mac_en, bus.busy, bus.mac_rst}),
        256'(6'b000001));
    chk("t6_rst_cfg", 256'(bus.mac_cfg), 256'(0));
    chk("t6_rst_ab", 256'({bus.mac_a, bus.mac_b}), 256'(0));
    chk("t6_rst_data", 256'(bus.rsp_data), 256'(0));
    bus.op_valid = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    tick();
    rst_n = 1'b1;
    tick();
    test_basic("t6_after", 1'b0, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
